// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports (CPU "c_*", DMA/debug loader "d_*") and the
// data-memory control bus of the dmem_arbiter.
//
// Handshake: a requester raises req with we/addr/wd/funct3 stable and keeps
// them stable until it sees gnt (one-cycle pulse, command latched). done is a
// one-cycle pulse one cycle after gnt; for loads, rdata is valid while done=1
// and holds until that port's next load completes. A req still high after
// gnt counts as a fresh request once the arbiter is idle again.
//
// Memory side: MemRead/MemWrite/a/wd/Funct3 are driven by the arbiter; rd is
// the memory's combinational read data, valid in the MemRead=1 cycle.
//
// Modports:
//   slave  - arbiter view (requests and rd in; grants, completions and the
//            memory control bus out)
//   master - requesters/memory view (the mirror image)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    // CPU port
    logic                  c_req;
    logic                  c_we;
    logic [DM_ADDRESS-1:0] c_addr;
    logic [DATA_W-1:0]     c_wd;
    logic [2:0]            c_funct3;
    logic                  c_gnt;
    logic                  c_done;
    logic [DATA_W-1:0]     c_rdata;

    // DMA/debug loader port
    logic                  d_req;
    logic                  d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wd;
    logic [2:0]            d_funct3;
    logic                  d_gnt;
    logic                  d_done;
    logic [DATA_W-1:0]     d_rdata;

    // Data memory bus
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [DATA_W-1:0]     rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wd, c_funct3,
        output c_gnt, c_done, c_rdata,
        input  d_req, d_we, d_addr, d_wd, d_funct3,
        output d_gnt, d_done, d_rdata,
        output MemRead, MemWrite, a, wd, Funct3,
        input  rd
    );

    modport master (
        output c_req, c_we, c_addr, c_wd, c_funct3,
        input  c_gnt, c_done, c_rdata,
        output d_req, d_we, d_addr, d_wd, d_funct3,
        input  d_gnt, d_done, d_rdata,
        input  MemRead, MemWrite, a, wd, Funct3,
        output rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of the data memory. Serialises CPU (port C) and
// DMA/debug (port D) accesses, drives the memory control bus for exactly one
// cycle per access and registers load data back to the winning port.
// Every access takes IDLE -> BUSY -> DONE (one access per 3 cycles at most).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   bus         dmem_arbiter_if.slave: both requester ports + memory bus
//   dbg_state_o current FSM state (0=IDLE, 1=BUSY, 2=DONE) for observation
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN - when defined the CPU always wins a tie and the
//   round-robin history register is removed (the DMA port can be starved).
//   When undefined, ties alternate, starting with the CPU after reset.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arbiter_if.slave         bus,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  owner_q;      // 0 = CPU, 1 = DMA
    logic                  cmd_we_q;
    logic [DM_ADDRESS-1:0] cmd_addr_q;
    logic [DATA_W-1:0]     cmd_wd_q;
    logic [2:0]            cmd_f3_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  c_gnt_q;
    logic                  d_gnt_q;
    logic                  c_done_q;
    logic                  d_done_q;
    logic [DATA_W-1:0]     c_rdata_q;
    logic [DATA_W-1:0]     d_rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                  last_q;       // last winner, 1 = DMA
`endif

    // Winner of the current IDLE cycle (1 = DMA) and its command.
    logic                  win_d;
    logic                  cmd_we_d;
    logic [DM_ADDRESS-1:0] cmd_addr_d;
    logic [DATA_W-1:0]     cmd_wd_d;
    logic [2:0]            cmd_f3_d;

    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win_d = ~bus.c_req;
`else
        // A tie goes to the port that did not win last time.
        if (bus.c_req && bus.d_req) begin
            win_d = ~last_q;
        end else begin
            win_d = ~bus.c_req;
        end
`endif
        cmd_we_d   = win_d ? bus.d_we     : bus.c_we;
        cmd_addr_d = win_d ? bus.d_addr   : bus.c_addr;
        cmd_wd_d   = win_d ? bus.d_wd     : bus.c_wd;
        cmd_f3_d   = win_d ? bus.d_funct3 : bus.c_funct3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wd_q    <= '0;
            cmd_f3_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            c_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            c_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            // Pulses default low; each is raised for one cycle below.
            c_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            c_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.c_req || bus.d_req) begin
                        state_q     <= S_BUSY;
                        owner_q     <= win_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_q      <= win_d;
`endif
                        cmd_we_q    <= cmd_we_d;
                        cmd_addr_q  <= cmd_addr_d;
                        cmd_wd_q    <= cmd_wd_d;
                        cmd_f3_q    <= cmd_f3_d;
                        c_gnt_q     <= ~win_d;
                        d_gnt_q     <= win_d;
                        // Memory strobes come up together with the command
                        // so the BUSY cycle is the single memory cycle.
                        mem_read_q  <= ~cmd_we_d;
                        mem_write_q <= cmd_we_d;
                    end
                end
                S_BUSY: begin
                    state_q  <= S_DONE;
                    c_done_q <= ~owner_q;
                    d_done_q <= owner_q;
                    if (!cmd_we_q) begin
                        if (owner_q) begin
                            d_rdata_q <= bus.rd;
                        end else begin
                            c_rdata_q <= bus.rd;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.c_gnt    = c_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.c_done   = c_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.MemRead  = mem_read_q;
    assign bus.MemWrite = mem_write_q;
    assign bus.a        = cmd_addr_q;
    assign bus.wd       = cmd_wd_q;
    assign bus.Funct3   = cmd_f3_q;
    assign dbg_state_o  = state_q;

endmodule
